// File: rtl/tick_pkg.sv
// Shared definitions for the programmable tick divider bank.
// Mode encodings and a width helper used to size the channel-select port.
package tick_pkg;

  typedef enum logic [1:0] {
    MODE_PERIODIC = 2'd0,
    MODE_SQUARE   = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_OFF      = 2'd3
  } tick_mode_e;

  // Index width for n items, never less than one bit so a single-channel bank still has a port.
  function automatic int clog2_min1(input int unsigned n);
    int r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One programmable clock-enable generator: up-counter with terminal-count compare,
// registered tick, square-wave level and one-shot arming.
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned      CNT_W     = 32,
  parameter logic [CNT_W-1:0] RESET_DIV = '0
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic             load,
  input  logic             restart,
  input  logic [CNT_W-1:0] new_div,
  input  logic [1:0]       new_mode,
  output logic             tick,
  output logic             level,
  output logic             armed
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_m1;
  tick_mode_e       mode;
  logic             active;
  logic             tc;

  // div == 0 is excluded by active, so the wrapped value of div_m1 is never used.
  assign div_m1 = div - CNT_W'(1);

  always_comb begin
    active = 1'b0;
    if (div != '0) begin
      case (mode)
        MODE_PERIODIC, MODE_SQUARE: active = 1'b1;
        MODE_ONESHOT:               active = armed;
        default:                    active = 1'b0;
      endcase
    end
  end

  assign tc = active && (cnt == div_m1);

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      div   <= RESET_DIV;
      mode  <= MODE_PERIODIC;
      cnt   <= '0;
      tick  <= 1'b0;
      level <= 1'b0;
      armed <= 1'b0;
    end else if (load || restart) begin
      // A write or restart overrides a coincident terminal count.
      if (load) begin
        div   <= new_div;
        mode  <= tick_mode_e'(new_mode);
        armed <= (new_mode == MODE_ONESHOT) && (new_div != '0);
      end else begin
        armed <= (mode == MODE_ONESHOT) && (div != '0);
      end
      cnt   <= '0;
      tick  <= 1'b0;
      level <= 1'b0;
    end else if (tc) begin
      tick <= 1'b1;
      cnt  <= '0;
      if (mode == MODE_SQUARE)  level <= ~level;
      if (mode == MODE_ONESHOT) armed <= 1'b0;
    end else begin
      tick <= 1'b0;
      cnt  <= active ? cnt + CNT_W'(1) : '0;
    end
  end

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of NUM_CH independent tick generators sharing one config write port
// and a common restart that phase-aligns every channel.
module tick_divider_bank
  import tick_pkg::*;
#(
  parameter int unsigned      CLK_FREQ  = 100_000_000,
  parameter int unsigned      NUM_CH    = 4,
  parameter int unsigned      CNT_W     = 32,
  parameter logic [CNT_W-1:0] RESET_DIV = CNT_W'(CLK_FREQ / 500),
  localparam int              CH_W      = clog2_min1(NUM_CH)
) (
  input  logic              clk_100mhz,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [1:0]        cfg_mode,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] armed
);

  logic [NUM_CH-1:0] load;

  // Indices at or beyond NUM_CH match no channel, so such writes are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = cfg_wr && (cfg_ch == CH_W'(i));

    tick_channel #(
      .CNT_W    (CNT_W),
      .RESET_DIV(RESET_DIV)
    ) u_ch (
      .clk_100mhz(clk_100mhz),
      .rst_n     (rst_n),
      .load      (load[i]),
      .restart   (sync_restart),
      .new_div   (cfg_div),
      .new_mode  (cfg_mode),
      .tick      (tick[i]),
      .level     (level[i]),
      .armed     (armed[i])
    );
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Self-checking bench for tick_divider_bank: per-cycle expectations from closed-form
// timing are queued at stimulus time and compared after each clock edge.
module tb_tick_divider_bank;

  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 16;
  localparam int RST_DIV = 5;
  localparam int CH_W    = tick_pkg::clog2_min1(NUM_CH);

  logic              clk_100mhz = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic [1:0]        cfg_mode = '0;
  logic              sync_restart = 1'b0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] armed;

  tick_divider_bank #(
    .CLK_FREQ (100_000_000),
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .RESET_DIV(CNT_W'(RST_DIV))
  ) dut (
    .clk_100mhz  (clk_100mhz),
    .rst_n       (rst_n),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_mode    (cfg_mode),
    .sync_restart(sync_restart),
    .tick        (tick),
    .level       (level),
    .armed       (armed)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    int                stamp;
    logic [NUM_CH-1:0] tk;
    logic [NUM_CH-1:0] lv;
    logic [NUM_CH-1:0] ar;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_div[NUM_CH];
  int   m_mode[NUM_CH];
  int   start[NUM_CH];
  bit   in_reset = 1'b1;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs of channel c after edge e, from edges elapsed since its last (re)start.
  function automatic void exp_ch(input int c, input int e, output bit t, output bit l, output bit a);
    int k;
    int d;
    k = e - start[c];
    d = m_div[c];
    t = 1'b0;
    l = 1'b0;
    a = 1'b0;
    if (in_reset || d == 0 || m_mode[c] == 3) return;
    case (m_mode[c])
      0: t = (k > 0) && (k % d == 0);
      1: begin
        t = (k > 0) && (k % d == 0);
        l = ((k / d) % 2) == 1;
      end
      2: begin
        t = (k == d);
        a = (k < d);
      end
      default: ;
    endcase
  endfunction

  task automatic step(input bit wr, input int ch, input int d, input int md, input bit rs, input bit rel);
    exp_t x;
    bit   t, l, a;
    @(negedge clk_100mhz);
    cfg_wr       = wr;
    cfg_ch       = CH_W'(ch);
    cfg_div      = CNT_W'(d);
    cfg_mode     = 2'(md);
    sync_restart = rs;
    if (rel) begin
      rst_n    = 1'b1;
      in_reset = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_div[c]  = RST_DIV;
        m_mode[c] = 0;
        start[c]  = cyc;
      end
    end
    if (!in_reset) begin
      if (wr && ch < NUM_CH) begin
        m_div[ch]  = d;
        m_mode[ch] = md;
        start[ch]  = cyc + 1;
      end
      if (rs) for (int c = 0; c < NUM_CH; c++) start[c] = cyc + 1;
    end
    x.stamp = cyc + 1;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_ch(c, cyc + 1, t, l, a);
      x.tk[c] = t;
      x.lv[c] = l;
      x.ar[c] = a;
    end
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic wr_cfg(input int ch, input int d, input int md);
    step(1'b1, ch, d, md, 1'b0, 1'b0);
  endtask

  always @(posedge clk_100mhz) begin : mon
    exp_t x;
    #1;
    while (sb.size() > 0 && sb[0].stamp <= cyc) begin
      x = sb.pop_front();
      chk_eq("tick",  32'(tick),  32'(x.tk));
      chk_eq("level", 32'(level), 32'(x.lv));
      chk_eq("armed", 32'(armed), 32'(x.ar));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c]  = RST_DIV;
      m_mode[c] = 0;
      start[c]  = 0;
    end

    // Reset state, then RESET_DIV ticks on every channel.
    idle(3);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(16);

    // Square wave on ch1.
    wr_cfg(1, 3, 1);
    idle(14);

    // One-shot on ch2, quiet period, then re-arm with the same values.
    wr_cfg(2, 4, 2);
    idle(24);
    wr_cfg(2, 4, 2);
    idle(8);

    // ch0 D=4, restart landing exactly on its terminal count.
    wr_cfg(0, 4, 0);
    idle(5);
    for (int i = 0; i < 8 && ((cyc + 2 - start[0]) % 4 != 0); i++) idle(1);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(10);

    // Divisor 0, divisor 1, out-of-range write, write coinciding with restart.
    wr_cfg(0, 0, 0);
    idle(6);
    wr_cfg(0, 1, 0);
    idle(6);
    wr_cfg(3, 2, 1);
    idle(8);
    step(1'b1, 1, 2, 1, 1'b1, 1'b0);
    idle(8);

    // Asynchronous reset between edges while ch0 is ticking continuously.
    @(posedge clk_100mhz);
    #3;
    rst_n    = 1'b0;
    in_reset = 1'b1;
    #1;
    chk_eq("async_rst_tick",  32'(tick),  32'd0);
    chk_eq("async_rst_level", 32'(level), 32'd0);
    chk_eq("async_rst_armed", 32'(armed), 32'd0);
    idle(2);
    step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle(12);

    @(posedge clk_100mhz);
    #2;
    chk_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
